// File: rtl/serial_adder.sv
// serial_adder: bit-serial WIDTH-bit adder built around one full-adder cell
// and a registered carry. Operands are captured on start, added LSB-first at
// one bit per clock, and the result is presented with a one-cycle done pulse.
// Optional feature macro: SERIAL_ADD_OVF_EN adds the signed-overflow output ovf.
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef SERIAL_ADD_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           next_state;

    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-2:0] sum_sh;
    logic             carry;
    logic [CW-1:0]    cnt;

    logic             cell_s;
    logic             cell_c;
    logic [WIDTH-1:0] sum_next;
    logic             last_bit;
    logic             load;

    // One-bit full-adder cell fed from the operand shift registers' LSBs.
    always_comb begin
        cell_s   = a_sh[0] ^ b_sh[0] ^ carry;
        cell_c   = (a_sh[0] & b_sh[0]) | (a_sh[0] & carry) | (b_sh[0] & carry);
        sum_next = {cell_s, sum_sh};
        last_bit = (cnt == CW'(WIDTH - 1));
        load     = start && ((state == IDLE) || (state == DONE));
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic: start is honoured only when not already running.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (start) next_state = RUN;
            end
            RUN: begin
                if (last_bit) next_state = DONE;
            end
            DONE: begin
                next_state = start ? RUN : IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // Operand/partial-sum shift registers, carry and bit counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh   <= '0;
            b_sh   <= '0;
            sum_sh <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
        end else if (load) begin
            a_sh   <= a;
            b_sh   <= b;
            sum_sh <= '0;
            carry  <= cin;
            cnt    <= '0;
        end else if (state == RUN) begin
            a_sh   <= a_sh >> 1;
            b_sh   <= b_sh >> 1;
            sum_sh <= sum_next[WIDTH-1:1];
            carry  <= cell_c;
            if (!last_bit) cnt <= cnt + 1'b1;
        end
    end

    // Result registers: updated only on the edge that finishes the last bit,
    // so partial sums are never visible. Carry at that point is the carry
    // into the MSB, which gives signed overflow when compared with carry-out.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum  <= '0;
            cout <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
            ovf  <= 1'b0;
`endif
        end else if ((state == RUN) && last_bit) begin
            sum  <= sum_next;
            cout <= cell_c;
`ifdef SERIAL_ADD_OVF_EN
            ovf  <= carry ^ cell_c;
`endif
        end
    end

    assign busy = (state == RUN);
    assign done = (state == DONE);

endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: directed-vector self-checking bench for serial_adder.
module tb_serial_adder;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic       busy;
    logic       done;
    logic [7:0] sum;
    logic       cout;
`ifdef SERIAL_ADD_OVF_EN
    logic       ovf;
`endif

    int vec_count   = 0;
    int miscompares = 0;

    serial_adder #(.WIDTH(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
`ifdef SERIAL_ADD_OVF_EN
        ,
        .ovf   (ovf)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Runs one add and observes 12 cycles after the start edge.
    task automatic do_add(input logic [7:0] av, input logic [7:0] bv, input logic cv,
                          output int busy_cycles, output int done_cycles,
                          output logic [7:0] sum_o, output logic cout_o, output logic ovf_o);
        busy_cycles = 0;
        done_cycles = 0;
        sum_o  = 8'h00;
        cout_o = 1'b0;
        ovf_o  = 1'b0;
        @(negedge clk);
        start = 1'b1;
        a     = av;
        b     = bv;
        cin   = cv;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (i == 0) start = 1'b0;
            if (busy) busy_cycles++;
            if (done) begin
                done_cycles++;
                sum_o  = sum;
                cout_o = cout;
`ifdef SERIAL_ADD_OVF_EN
                ovf_o  = ovf;
`endif
            end
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        start = 1'b0;
        a     = 8'h00;
        b     = 8'h00;
        cin   = 1'b0;
        repeat (2) @(negedge clk);
        vec_count++;
        if ({busy, done, sum, cout} !== 11'h000) begin
            miscompares++;
            $display("FAIL reset_outputs: busy=%b done=%b sum=%h cout=%b, expected all 0", busy, done, sum, cout);
        end
`ifdef SERIAL_ADD_OVF_EN
        vec_count++;
        if (ovf !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_ovf: got %b expected 0", ovf);
        end
`endif
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        vec_count++;
        if ({busy, done} !== 2'b00) begin
            miscompares++;
            $display("FAIL idle_after_reset: busy=%b done=%b expected 0 0", busy, done);
        end
    endtask

    task automatic test_add_vectors;
        logic [7:0] va [5] = '{8'h00, 8'hFF, 8'h5A, 8'h3C, 8'hAA};
        logic [7:0] vb [5] = '{8'h00, 8'h01, 8'hA5, 8'h47, 8'h55};
        logic       vc [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        logic [7:0] es [5] = '{8'h00, 8'h00, 8'h00, 8'h83, 8'hFF};
        logic       ec [5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        int bc, dc;
        logic [7:0] s;
        logic co, ov;
        for (int k = 0; k < 5; k++) begin
            do_add(va[k], vb[k], vc[k], bc, dc, s, co, ov);
            vec_count++;
            if (bc !== 8) begin
                miscompares++;
                $display("FAIL vec%0d busy_cycles: got %0d expected 8", k, bc);
            end
            vec_count++;
            if (dc !== 1) begin
                miscompares++;
                $display("FAIL vec%0d done_pulses: got %0d expected 1", k, dc);
            end
            vec_count++;
            if (s !== es[k]) begin
                miscompares++;
                $display("FAIL vec%0d sum: got %h expected %h", k, s, es[k]);
            end
            vec_count++;
            if (co !== ec[k]) begin
                miscompares++;
                $display("FAIL vec%0d cout: got %b expected %b", k, co, ec[k]);
            end
        end
    endtask

`ifdef SERIAL_ADD_OVF_EN
    task automatic test_ovf;
        logic [7:0] va [3] = '{8'h7F, 8'h80, 8'h10};
        logic [7:0] vb [3] = '{8'h01, 8'h80, 8'h20};
        logic [7:0] es [3] = '{8'h80, 8'h00, 8'h30};
        logic       ec [3] = '{1'b0, 1'b1, 1'b0};
        logic       eo [3] = '{1'b1, 1'b1, 1'b0};
        int bc, dc;
        logic [7:0] s;
        logic co, ov;
        for (int k = 0; k < 3; k++) begin
            do_add(va[k], vb[k], 1'b0, bc, dc, s, co, ov);
            vec_count++;
            if ({s, co, ov} !== {es[k], ec[k], eo[k]}) begin
                miscompares++;
                $display("FAIL ovf%0d: got sum=%h cout=%b ovf=%b expected sum=%h cout=%b ovf=%b",
                         k, s, co, ov, es[k], ec[k], eo[k]);
            end
            vec_count++;
            if (ovf !== eo[k]) begin
                miscompares++;
                $display("FAIL ovf%0d_held: got %b expected %b", k, ovf, eo[k]);
            end
        end
    endtask
`endif

    task automatic test_mid_run_ignore;
        int dc = 0;
        logic [7:0] s = 8'h00;
        logic co = 1'b1;
        @(negedge clk);
        start = 1'b1;
        a     = 8'h12;
        b     = 8'h34;
        cin   = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (i == 0) start = 1'b0;
            if (i == 3) begin
                start = 1'b1;
                a     = 8'hFF;
                b     = 8'hFF;
                cin   = 1'b1;
            end
            if (i == 4) start = 1'b0;
            if (done) begin
                dc++;
                s  = sum;
                co = cout;
            end
        end
        vec_count++;
        if (dc !== 1) begin
            miscompares++;
            $display("FAIL midrun_done_pulses: got %0d expected 1", dc);
        end
        vec_count++;
        if ({s, co} !== {8'h46, 1'b0}) begin
            miscompares++;
            $display("FAIL midrun_result: got sum=%h cout=%b expected sum=46 cout=0", s, co);
        end
    endtask

    task automatic test_back_to_back;
        int first_i = -1;
        int second_i = -1;
        logic [7:0] s1 = 8'hxx;
        logic [7:0] s2 = 8'hxx;
        logic hold_ok = 1'b1;
        logic busy9 = 1'b0;
        @(negedge clk);
        start = 1'b1;
        a     = 8'h10;
        b     = 8'h20;
        cin   = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (i == 0) begin
                a = 8'h01;
                b = 8'h02;
            end
            if (i == 9) begin
                start = 1'b0;
                busy9 = busy;
            end
            if (i >= 9 && i <= 16 && sum !== 8'h30) hold_ok = 1'b0;
            if (done) begin
                if (first_i < 0) begin
                    first_i = i;
                    s1 = sum;
                end else if (second_i < 0) begin
                    second_i = i;
                    s2 = sum;
                end
            end
        end
        vec_count++;
        if (first_i !== 8 || s1 !== 8'h30) begin
            miscompares++;
            $display("FAIL b2b_first: done at %0d sum=%h expected done at 8 sum=30", first_i, s1);
        end
        vec_count++;
        if (busy9 !== 1'b1) begin
            miscompares++;
            $display("FAIL b2b_restart_busy: got %b expected 1", busy9);
        end
        vec_count++;
        if (hold_ok !== 1'b1) begin
            miscompares++;
            $display("FAIL b2b_sum_hold: got changed expected held at 30");
        end
        vec_count++;
        if (second_i - first_i !== 9 || s2 !== 8'h03) begin
            miscompares++;
            $display("FAIL b2b_second: gap=%0d sum=%h expected gap=9 sum=03", second_i - first_i, s2);
        end
    endtask

    task automatic test_reset_mid_run;
        int bc, dc;
        logic [7:0] s;
        logic co, ov;
        do_add(8'h7F, 8'h81, 1'b0, bc, dc, s, co, ov);
        vec_count++;
        if ({s, co} !== {8'h00, 1'b1}) begin
            miscompares++;
            $display("FAIL prereset_result: got sum=%h cout=%b expected sum=00 cout=1", s, co);
        end
        do_add(8'h7F, 8'h01, 1'b0, bc, dc, s, co, ov);
        @(negedge clk);
        start = 1'b1;
        a     = 8'hFF;
        b     = 8'h01;
        cin   = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (i == 0) start = 1'b0;
        end
        rst_n = 1'b0;
        #1;
        vec_count++;
        if ({busy, done, sum, cout} !== 11'h000) begin
            miscompares++;
            $display("FAIL midrun_reset: busy=%b done=%b sum=%h cout=%b expected all 0", busy, done, sum, cout);
        end
`ifdef SERIAL_ADD_OVF_EN
        vec_count++;
        if (ovf !== 1'b0) begin
            miscompares++;
            $display("FAIL midrun_reset_ovf: got %b expected 0", ovf);
        end
`endif
        @(negedge clk);
        rst_n = 1'b1;
        bc = 0;
        dc = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (busy) bc++;
            if (done) dc++;
        end
        vec_count++;
        if (bc !== 0 || dc !== 0) begin
            miscompares++;
            $display("FAIL post_reset_quiet: busy_cycles=%0d done_pulses=%0d expected 0 0", bc, dc);
        end
    endtask

    initial begin
        test_reset();
        test_add_vectors();
`ifdef SERIAL_ADD_OVF_EN
        test_ovf();
`endif
        test_mid_run_ignore();
        test_back_to_back();
        test_reset_mid_run();
        $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] simulation timed out");
    end

endmodule
